// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, request codes and LCD command bytes
package lcd_pkg;
  typedef enum logic [3:0] {
    INIT_FS, INIT_EM, INIT_DC, INIT_CLR, LINE_CMD, RD_REQ, RD_WAIT, WR_HI, WR_LO, IDLE
  } state_t;
  typedef enum logic [1:0] {REQ_REFRESH, REQ_UP, REQ_DOWN} req_t;
  localparam logic [7:0] FUNC_SET   = 8'h28;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] DDRAM_L0   = 8'h80;
  localparam logic [7:0] DDRAM_L1   = 8'hC0;
  localparam int CHARS_PER_LINE = 16;
endpackage

// File: rtl/lcd_req_latch.sv
// lcd_req_latch: resolves scroll/refresh pulses and holds one pending request
module lcd_req_latch
  import lcd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scroll_up,
  input  logic scroll_down,
  input  logic refresh,
  input  logic consume,
  output logic req_valid,
  output req_t req_dir
);
  logic up, dn, hit, pend;
  req_t cur, pend_dir;
  // opposing scrolls cancel; a scroll outranks a plain refresh
  always_comb begin
    up        = scroll_up && !scroll_down;
    dn        = scroll_down && !scroll_up;
    hit       = up || dn || refresh;
    cur       = up ? REQ_UP : dn ? REQ_DOWN : REQ_REFRESH;
    req_valid = hit || pend;
    req_dir   = hit ? cur : pend_dir;
  end
  // latest request overwrites the pending one until the sequencer consumes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= 1'b0;
      pend_dir <= REQ_REFRESH;
    end else if (consume) begin
      pend     <= 1'b0;
    end else if (hit) begin
      pend     <= 1'b1;
      pend_dir <= cur;
    end
  end
endmodule

// File: rtl/lcd_page_sequencer.sv
// lcd_page_sequencer: drives lcd_driver through init, then paints a 2x16 RAM window
module lcd_page_sequencer
  import lcd_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int RD_LAT         = 1,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_rdy,
  output logic              lcd_write,
  output logic [7:0]        lcd_data,
  output logic              lcd_data1cmd0,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [15:0]       mem_rd_data,
  input  logic              scroll_up,
  input  logic              scroll_down,
  input  logic              refresh,
  output logic              busy,
  output logic [ADDR_W-1:0] base_addr
);
  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);
  state_t state, state_nx;
  req_t req_dir;
  logic holdoff, go, line, req_valid, is_data, dc_q, strobe_st;
  logic [WW-1:0] word;
  logic [1:0] cnt;
  logic [15:0] hold;
  logic [7:0] cur_byte, data_q;
  // holdoff is set during reset so no strobe can escape while it is asserted
  assign go = lcd_rdy && !holdoff;
  lcd_req_latch u_req (
    .clk        (clk),
    .reset      (reset),
    .scroll_up  (scroll_up),
    .scroll_down(scroll_down),
    .refresh    (refresh),
    .consume    (state == IDLE),
    .req_valid  (req_valid),
    .req_dir    (req_dir)
  );
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT_FS;
    else state <= state_nx;
  end
  // next-state: strobe states advance only when a strobe is issued
  always_comb begin
    state_nx = state;
    case (state)
      INIT_FS:  state_nx = go ? INIT_EM : INIT_FS;
      INIT_EM:  state_nx = go ? INIT_DC : INIT_EM;
      INIT_DC:  state_nx = go ? INIT_CLR : INIT_DC;
      INIT_CLR: state_nx = go ? LINE_CMD : INIT_CLR;
      LINE_CMD: state_nx = go ? RD_REQ : LINE_CMD;
      RD_REQ:   state_nx = RD_WAIT;
      RD_WAIT:  state_nx = cnt == 2'(RD_LAT) ? WR_HI : RD_WAIT;
      WR_HI:    state_nx = go ? WR_LO : WR_HI;
      WR_LO:    state_nx = !go ? WR_LO : word != LAST_WORD ? RD_REQ : !line ? LINE_CMD : IDLE;
      IDLE:     state_nx = req_valid ? LINE_CMD : IDLE;
      default:  state_nx = INIT_FS;
    endcase
  end
  // outputs: strobe byte is live in the strobe cycle, otherwise the last one is held
  always_comb begin
    cur_byte  = 8'h00;
    is_data   = 1'b0;
    strobe_st = 1'b1;
    case (state)
      INIT_FS:  cur_byte = FUNC_SET;
      INIT_EM:  cur_byte = ENTRY_MODE;
      INIT_DC:  cur_byte = DISP_ON;
      INIT_CLR: cur_byte = CLEAR;
      LINE_CMD: cur_byte = line ? DDRAM_L1 : DDRAM_L0;
      WR_HI: begin
        cur_byte = hold[15:8];
        is_data  = 1'b1;
      end
      WR_LO: begin
        cur_byte = hold[7:0];
        is_data  = 1'b1;
      end
      default:  strobe_st = 1'b0;
    endcase
    lcd_write     = strobe_st && go;
    lcd_data      = lcd_write ? cur_byte : data_q;
    lcd_data1cmd0 = lcd_write ? is_data : dc_q;
    mem_rd_en     = state == RD_REQ;
    mem_rd_addr   = base_addr + ADDR_W'(line ? WORDS_PER_LINE : 0) + ADDR_W'(word);
    busy          = state != IDLE;
  end
  // datapath: handshake holdoff, read latency count, window position and base
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdoff   <= 1'b1;
      data_q    <= 8'h00;
      dc_q      <= 1'b0;
      cnt       <= 2'd1;
      hold      <= 16'h0000;
      line      <= 1'b0;
      word      <= '0;
      base_addr <= '0;
    end else begin
      holdoff <= lcd_write;
      cnt     <= state == RD_WAIT ? cnt + 2'd1 : 2'd1;
      if (lcd_write) begin
        data_q <= lcd_data;
        dc_q   <= lcd_data1cmd0;
      end
      if (state == RD_WAIT && cnt == 2'(RD_LAT)) hold <= mem_rd_data;
      if (state == WR_LO && lcd_write) begin
        word <= word == LAST_WORD ? '0 : word + 1'b1;
        line <= line || word == LAST_WORD;
      end
      if (state == IDLE && req_valid) begin
        line      <= 1'b0;
        word      <= '0;
        base_addr <= req_dir == REQ_DOWN ? base_addr + ADDR_W'(WORDS_PER_LINE) :
                     req_dir == REQ_UP ? base_addr - ADDR_W'(WORDS_PER_LINE) : base_addr;
      end
    end
  end
endmodule

// File: tb/tb_lcd_page_sequencer.sv
// tb_lcd_page_sequencer: scoreboard bench for two sequencers (RD_LAT 1 and 3)
module tb_lcd_page_sequencer;
  localparam int AW = 10;
  localparam int WPL = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scroll_up = 1'b0;
  logic scroll_down = 1'b0;
  logic refresh = 1'b0;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
    logic [7:0] hi, lo;
    hi = 8'h41 + a[7:0];
    lo = (8'h61 + a[7:0]) ^ {6'b0, a[9:8]};
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = g == 0 ? 1 : 3;
    logic lcd_rdy, lcd_write, lcd_data1cmd0, mem_rd_en, busy;
    logic [7:0] lcd_data;
    logic [AW-1:0] mem_rd_addr, base_addr;
    logic [15:0] mem_rd_data;
    logic [4:0] bcnt = 5'd0;
    logic dly = 1'b0;
    logic wr_d = 1'b0;
    logic en_p [LAT];
    logic [AW-1:0] a_p [LAT];
    logic [8:0] q[$];
    int nstrobe = 0;
    int ndata = 0;
    lcd_page_sequencer #(.ADDR_W(AW), .RD_LAT(LAT), .WORDS_PER_LINE(WPL)) dut (
      .clk          (clk),
      .reset        (reset),
      .lcd_rdy      (lcd_rdy),
      .lcd_write    (lcd_write),
      .lcd_data     (lcd_data),
      .lcd_data1cmd0(lcd_data1cmd0),
      .mem_rd_en    (mem_rd_en),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_data  (mem_rd_data),
      .scroll_up    (scroll_up),
      .scroll_down  (scroll_down),
      .refresh      (refresh),
      .busy         (busy),
      .base_addr    (base_addr)
    );
    // driver model: ready stays high one cycle after a strobe, then busy 1..20 cycles
    assign lcd_rdy = bcnt == 5'd0;
    always @(posedge clk) begin
      bcnt <= bcnt != 5'd0 ? bcnt - 5'd1 : 5'd0;
      if (dly) bcnt <= 5'($urandom_range(20, 1));
      dly <= lcd_write;
    end
    // RAM model: data valid only exactly LAT cycles after the read pulse
    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
        en_p[i] <= en_p[i-1];
        a_p[i]  <= a_p[i-1];
      end
      en_p[0] <= mem_rd_en;
      a_p[0]  <= mem_rd_addr;
    end
    assign mem_rd_data = en_p[LAT-1] ? ram_word(a_p[LAT-1]) : 16'hDEAD;
    // monitor: every strobe is checked against the scoreboard queue
    always @(negedge clk) begin
      if (!reset && lcd_write) begin
        check("strobe_rdy", 32'(lcd_rdy), 32'd1);
        check("strobe_holdoff", 32'(wr_d), 32'd0);
        if (q.size() == 0) check("extra_strobe", 32'({lcd_data1cmd0, lcd_data}), 32'h200);
        else check("strobe", 32'({lcd_data1cmd0, lcd_data}), 32'(q.pop_front()));
        nstrobe++;
        if (lcd_data1cmd0) ndata++;
      end
      wr_d = lcd_write;
    end
  end

  task automatic push_all(input logic dc, input logic [7:0] b);
    u[0].q.push_back({dc, b});
    u[1].q.push_back({dc, b});
  endtask

  task automatic push_init();
    push_all(1'b0, 8'h28);
    push_all(1'b0, 8'h06);
    push_all(1'b0, 8'h0C);
    push_all(1'b0, 8'h01);
  endtask

  task automatic push_paint(input logic [AW-1:0] b);
    logic [15:0] w;
    for (int l = 0; l < 2; l++) begin
      push_all(1'b0, l == 0 ? 8'h80 : 8'hC0);
      for (int k = 0; k < WPL; k++) begin
        w = ram_word(b + AW'(l * WPL + k));
        push_all(1'b1, w[15:8]);
        push_all(1'b1, w[7:0]);
      end
    end
  endtask

  task automatic pulse(input logic up, input logic dn, input logic rf);
    @(posedge clk);
    #1 scroll_up = up; scroll_down = dn; refresh = rf;
    @(posedge clk);
    #1 scroll_up = 1'b0; scroll_down = 1'b0; refresh = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(posedge clk);
    #1;
    while ((u[0].busy || u[1].busy) && n < 6000) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 6000) check("idle_timeout", 32'd1, 32'd0);
    check("queue0_drained", 32'(u[0].q.size()), 32'd0);
    check("queue1_drained", 32'(u[1].q.size()), 32'd0);
  endtask

  task automatic check_rst();
    check("rst_vals0", {u[0].lcd_write, u[0].lcd_data, u[0].lcd_data1cmd0, u[0].mem_rd_en,
                        u[0].mem_rd_addr, u[0].base_addr, u[0].busy}, 32'h1);
    check("rst_vals1", {u[1].lcd_write, u[1].lcd_data, u[1].lcd_data1cmd0, u[1].mem_rd_en,
                        u[1].mem_rd_addr, u[1].base_addr, u[1].busy}, 32'h1);
  endtask

  initial begin
    int s0, s1, d0, n;
    repeat (3) @(posedge clk);
    #1 check_rst();
    push_init();
    push_paint(10'd0);
    reset = 1'b0;
    wait_idle();
    check("init_strobes0", 32'(u[0].nstrobe), 32'd38);
    check("init_strobes1", 32'(u[1].nstrobe), 32'd38);
    check("base_init", 32'(u[0].base_addr), 32'd0);
    push_paint(10'd8);
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle();
    check("base_down0", 32'(u[0].base_addr), 32'd8);
    check("base_down1", 32'(u[1].base_addr), 32'd8);
    push_paint(10'd0);
    pulse(1'b1, 1'b0, 1'b0);
    wait_idle();
    check("base_up", 32'(u[0].base_addr), 32'd0);
    push_paint(10'd1016);
    pulse(1'b1, 1'b0, 1'b0);
    wait_idle();
    check("base_wrap0", 32'(u[0].base_addr), 32'd1016);
    check("base_wrap1", 32'(u[1].base_addr), 32'd1016);
    push_paint(10'd0);
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle();
    check("base_unwrap", 32'(u[0].base_addr), 32'd0);
    push_paint(10'd0);
    push_paint(10'd1016);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    check("mid_paint_base", {u[0].busy, u[1].busy, 20'(u[0].base_addr), 10'(u[1].base_addr)}, 32'hC000_0000);
    wait_idle();
    check("pending_base0", 32'(u[0].base_addr), 32'd1016);
    check("pending_base1", 32'(u[1].base_addr), 32'd1016);
    s0 = u[0].nstrobe;
    s1 = u[1].nstrobe;
    pulse(1'b1, 1'b1, 1'b0);
    repeat (40) @(posedge clk);
    #1 check("null_req", {u[0].busy, u[1].busy, 30'(u[0].nstrobe - s0 + u[1].nstrobe - s1)}, 32'd0);
    check("null_base", 32'(u[0].base_addr), 32'd1016);
    push_paint(10'd1016);
    d0 = u[0].ndata;
    pulse(1'b0, 1'b0, 1'b1);
    n = 0;
    while (u[0].ndata - d0 < 10 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 6000) check("data10_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_rst();
    u[0].q.delete();
    u[1].q.delete();
    push_init();
    push_paint(10'd0);
    s0 = u[0].nstrobe;
    s1 = u[1].nstrobe;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_idle();
    check("reinit_strobes0", 32'(u[0].nstrobe - s0), 32'd38);
    check("reinit_strobes1", 32'(u[1].nstrobe - s1), 32'd38);
    check("reinit_base", 32'(u[1].base_addr), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end
endmodule
